pwm_bank_ctrl: RTL and testbench
================================

Name: pwm_bank_ctrl

Overview:
Parametrised multi-channel PWM engine, the successor to the fixed 8-channel, 10-bit PWM array with its separate clock divider. It carries a programmable period, per-channel double-buffered duty registers, per-channel output polarity and an integrated prescaler, all behind one register-write handshake. It sits between the SPI register decoder and the uo_out pads. The single counter runs on the system clock, so no divided clock is used as a clock anywhere.

Parameters:
NUM_CH, 8, number of PWM channels (1..13).
CNT_W, 10, width of period counter and duty/period registers.
DIV_W, 4, prescaler register width; tick every (div+1) clk cycles.
ADDR_W, 4, register address width.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  global run enable, level, synchronous.
wr_valid  input  1  register write request.
wr_ready  output  1  write accepted when wr_valid && wr_ready.
wr_addr  input  ADDR_W  register address.
wr_data  input  16  write data, LSB-aligned.
pwm_out  output  NUM_CH  registered PWM outputs.
period_start  output  1  one-clk pulse when the counter wraps to 0.
wr_err  output  1  one-clk pulse on an accepted write to an unmapped address.

Behaviour:
- Reset (async, rst_n low) values:
  - all duty shadow/active registers = 0
  - period shadow/active = 2^CNT_W-1
  - div = 0
  - polarity = 0
  - prescaler count = 0, counter = 0
  - pwm_out = 0, period_start = 0, wr_err = 0
  - wr_ready = 0 while in reset, then 1.
- wr_ready is 1 at all times out of reset; every write completes in one cycle.
- Address map, all written on the accepting edge:
  - 0..NUM_CH-1: duty shadow[addr] <= wr_data[CNT_W-1:0].
  - NUM_CH: div <= wr_data[DIV_W-1:0]. Takes effect immediately; the prescaler count is cleared to 0 in the same edge.
  - NUM_CH+1: period shadow <= wr_data[CNT_W-1:0].
  - NUM_CH+2: polarity <= wr_data[NUM_CH-1:0]. Takes effect immediately.
  - Any other address: no register change; wr_err pulses for 1 cycle on the following edge.
- Prescaler: psc counts 0..div.
  - tick = ena && (psc == div); psc returns to 0 on tick.
  - div = 0 gives a tick every cycle.
- Counter: on tick, cnt <= (cnt == period_active) ? 0 : cnt+1.
- Wrap event = tick && cnt == period_active. On a wrap:
  - every duty_active <= duty shadow, period_active <= period shadow (atomic)
  - period_start pulses for 1 cycle, registered, coincident with cnt becoming 0.
- Write and wrap on the same edge: the wrap loads the OLD shadow value. The new value applies at the next wrap.
- Output: pwm_out[i] <= (cnt < duty_active[i]) ^ polarity[i].
  - This is a registered output: 1 clk after cnt.
  - duty = 0: constant inactive level.
  - duty > period_active: constant active level (100%); no wrap-around of the comparison.
- Period length = (period_active+1)*(div+1) clk cycles.
- ena low:
  - psc and cnt are held at 0.
  - active registers track the shadows every cycle.
  - pwm_out[i] <= polarity[i] (idle level); no period_start.
  - Writes are still accepted.
- ena rising: counting restarts from cnt = 0 with the current shadows. The first period_start occurs after one full period.
- Reset mid-period: immediate async clear to the reset values; no partial pulse is completed.

Decomposition:
- Shared package pwm_pkg holds:
  - address offset constants ADDR_DIV_OFS=0, ADDR_PER_OFS=1, ADDR_POL_OFS=2, relative to NUM_CH
  - reset-value constants
  - the compile-time check NUM_CH+3 <= 2^ADDR_W.
- One sub-module, pwm_prescaler: div register use, psc counter, tick generation, clear-on-write.
- Per-channel compare logic is a generate loop inside pwm_bank_ctrl, not a separate module.

Test Plan:
- Reset defaults, ena=1, no writes:
  - period = 1024 clk
  - pwm_out = 0x00
  - period_start every 1024 cycles
  - wr_ready = 1
- Period 9, div 0, duty ch0 = 3, ch1 = 0, ch2 = 12:
  - after the first wrap, ch0 is high 3 of every 10 clks, ch1 is always low, ch2 is always high
  - period_start spacing = 10.
- div = 2, period = 4, duty ch3 = 2: ch3 is high 6 clks, low 9 clks, repeating; period_start spacing = 15 clks.
- Write duty ch0 = 7 on the exact wrap edge (old = 3, period 9): the current period uses 3, the next period uses 7. Write the period shadow mid-period: no change until the wrap.
- polarity = 0x05 with ena=0: pwm_out = 0x05 next cycle. Raise ena: counting starts from cnt 0, and the first period_start comes exactly (period+1)*(div+1) cycles later.
- Write to address NUM_CH+3: wr_err pulses once; all registers unchanged. Assert rst_n low mid-period: pwm_out = 0 immediately (async) and defaults are restored.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM bank: register map offsets above the duty
// registers, reset values and the address-space fit check.
package pwm_pkg;

  localparam int ADDR_DIV_OFS = 0;
  localparam int ADDR_PER_OFS = 1;
  localparam int ADDR_POL_OFS = 2;
  localparam int NUM_CFG_REGS = 3;

  localparam int DUTY_RST = 0;
  localparam int DIV_RST  = 0;
  localparam int POL_RST  = 0;

  // Duty registers plus the three config registers must fit the address space.
  function automatic bit addr_map_fits(input int num_ch, input int addr_w);
    return (num_ch + NUM_CFG_REGS) <= (1 << addr_w);
  endfunction

endpackage

// File: rtl/pwm_bank_ctrl_prescaler.sv
// Clock-enable prescaler: emits tick every (div+1) cycles while ena is high,
// restarting its count whenever div is rewritten.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             div_we,
  input  logic [DIV_W-1:0] div_wdata,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] psc_q;
  logic [DIV_W-1:0] psc_d;

  assign tick = ena && (psc_q == div_q);

  always_comb begin
    psc_d = psc_q;
    if (div_we || !ena || tick) begin
      psc_d = '0;
    end else begin
      psc_d = psc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DIV_RST);
      psc_q <= '0;
    end else begin
      if (div_we) div_q <= div_wdata;
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// Multi-channel PWM engine: shared period counter, double-buffered duty and
// period registers swapped atomically at wrap, per-channel polarity.
module pwm_bank_ctrl
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 10,
  parameter int DIV_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              wr_err
);

  if (!addr_map_fits(NUM_CH, ADDR_W)) begin : g_bad_cfg
    $error("pwm_bank_ctrl: NUM_CH+3 registers do not fit in ADDR_W address bits");
  end

  localparam logic [ADDR_W-1:0] A_DIV = ADDR_W'(NUM_CH + ADDR_DIV_OFS);
  localparam logic [ADDR_W-1:0] A_PER = ADDR_W'(NUM_CH + ADDR_PER_OFS);
  localparam logic [ADDR_W-1:0] A_POL = ADDR_W'(NUM_CH + ADDR_POL_OFS);

  logic              wr_ready_q;
  logic              wr_err_q;
  logic              pstart_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_sh_q, per_act_q;
  logic [NUM_CH-1:0] pol_q;
  logic              wr_fire, sel_duty, sel_div, sel_per, sel_pol;
  logic              tick, wrap, load_act;
  logic              unused_wr_data;

  assign unused_wr_data = ^wr_data;

  assign wr_ready     = wr_ready_q;
  assign wr_err       = wr_err_q;
  assign period_start = pstart_q;

  assign wr_fire  = wr_valid && wr_ready_q;
  assign sel_duty = int'(wr_addr) < NUM_CH;
  assign sel_div  = (wr_addr == A_DIV);
  assign sel_per  = (wr_addr == A_PER);
  assign sel_pol  = (wr_addr == A_POL);

  pwm_prescaler #(.DIV_W(DIV_W)) u_psc (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .div_we    (wr_fire && sel_div),
    .div_wdata (wr_data[DIV_W-1:0]),
    .tick      (tick)
  );

  assign wrap = tick && (cnt_q == per_act_q);
  // While idle the active copies follow the shadows so a restart uses fresh values.
  assign load_act = !ena || wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!ena || wrap) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
      pstart_q   <= 1'b0;
      cnt_q      <= '0;
      per_sh_q   <= '1;
      per_act_q  <= '1;
      pol_q      <= NUM_CH'(POL_RST);
    end else begin
      wr_ready_q <= 1'b1;
      wr_err_q   <= wr_fire && !(sel_duty || sel_div || sel_per || sel_pol);
      pstart_q   <= wrap;
      cnt_q      <= cnt_d;
      if (load_act) per_act_q <= per_sh_q;
      if (wr_fire && sel_per) per_sh_q <= wr_data[CNT_W-1:0];
      if (wr_fire && sel_pol) pol_q <= wr_data[NUM_CH-1:0];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_sh_q, duty_act_q;
    logic             pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_sh_q  <= CNT_W'(DUTY_RST);
        duty_act_q <= CNT_W'(DUTY_RST);
        pwm_q      <= 1'b0;
      end else begin
        if (wr_fire && (wr_addr == ADDR_W'(i))) duty_sh_q <= wr_data[CNT_W-1:0];
        if (load_act) duty_act_q <= duty_sh_q;
        pwm_q <= ena ? ((cnt_q < duty_act_q) ^ pol_q[i]) : pol_q[i];
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Directed bench for pwm_bank_ctrl: period spacing, duty counts per period,
// shadow timing, polarity idle level, unmapped writes and async reset.
module tb_pwm_bank_ctrl;

  localparam int NUM_CH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  pwm_out;
  logic        period_start;
  logic        wr_err;

  int nchk = 0;
  int nerr = 0;
  int hi [NUM_CH];
  int n;

  pwm_bank_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .wr_err       (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Cycles until the next period_start (bounded), with per-channel high counts.
  task automatic wait_ps(input int max_cyc, output int cyc);
    cyc = 0;
    for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
    while (cyc < max_cyc) begin
      step();
      cyc++;
      for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) hi[c]++;
      if (period_start) break;
    end
  endtask

  function automatic int hi_sum();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += hi[c];
    return s;
  endfunction

  initial begin
    rst_n = 1'b0; ena = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #2;
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_wr_err", int'(wr_err), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("wr_ready_after_rst", int'(wr_ready), 1);

    // Defaults: 1024-cycle period, outputs low
    ena = 1'b1;
    wait_ps(2000, n);
    check("dflt_first_period", n, 1024);
    wait_ps(2000, n);
    check("dflt_period", n, 1024);
    check("dflt_pwm_high_sum", hi_sum(), 0);
    check("dflt_wr_ready", int'(wr_ready), 1);

    // period 9, div 0, duty ch0=3 ch1=0 ch2=12
    ena = 1'b0;
    write(4'd9, 16'd9);
    write(4'd0, 16'd3);
    write(4'd1, 16'd0);
    write(4'd2, 16'd12);
    check("mapped_no_err", int'(wr_err), 0);
    ena = 1'b1;
    wait_ps(100, n);
    check("p9_first_period", n, 10);
    wait_ps(100, n);
    check("p9_period", n, 10);
    check("p9_ch0_hi", hi[0], 3);
    check("p9_ch1_hi", hi[1], 0);
    check("p9_ch2_hi", hi[2], 10);

    // duty write landing on the wrap edge: old value for this period
    repeat (9) step();
    write(4'd0, 16'd7);
    check("wrap_edge_pstart", int'(period_start), 1);
    wait_ps(100, n);
    check("wrap_edge_len", n, 10);
    check("wrap_edge_old_duty", hi[0], 3);
    wait_ps(100, n);
    check("next_period_new_duty", hi[0], 7);

    // period shadow written mid-period: applies after the wrap
    repeat (4) step();
    write(4'd9, 16'd5);
    wait_ps(100, n);
    check("per_mid_remaining", n, 5);
    wait_ps(100, n);
    check("per_new_len", n, 6);
    check("per_new_ch0_hi", hi[0], 6);
    check("per_new_ch1_hi", hi[1], 0);
    check("per_new_ch2_hi", hi[2], 6);

    // div 2, period 4, duty ch3=2
    ena = 1'b0;
    write(4'd8, 16'd2);
    write(4'd9, 16'd4);
    write(4'd3, 16'd2);
    ena = 1'b1;
    wait_ps(100, n);
    check("div2_first_period", n, 15);
    wait_ps(100, n);
    check("div2_period", n, 15);
    check("div2_ch3_hi", hi[3], 6);
    check("div2_ch0_full", hi[0], 15);

    // polarity 0x05 while idle, then restart
    ena = 1'b0;
    write(4'd10, 16'h0005);
    check("pol_write_edge", int'(pwm_out), 0);
    step();
    check("pol_idle_level", int'(pwm_out), 5);
    ena = 1'b1;
    wait_ps(100, n);
    check("restart_first_pstart", n, 15);
    wait_ps(100, n);
    check("pol_ch0_hi", hi[0], 0);
    check("pol_ch2_hi", hi[2], 0);
    check("pol_ch3_hi", hi[3], 6);

    // unmapped address
    check("err_idle", int'(wr_err), 0);
    write(4'd11, 16'hFFFF);
    check("err_pulse", int'(wr_err), 1);
    step();
    check("err_one_cycle", int'(wr_err), 0);
    wait_ps(100, n);
    check("err_remaining", n, 13);
    wait_ps(100, n);
    check("err_period_kept", n, 15);
    check("err_ch3_kept", hi[3], 6);
    check("err_ch0_kept", hi[0], 0);
    check("err_ch7_kept", hi[7], 0);

    // async reset mid-period
    step(); step();
    check("pre_rst_pwm", int'(pwm_out), 8);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_wr_ready", int'(wr_ready), 0);
    check("async_rst_pstart", int'(period_start), 0);
    step();
    rst_n = 1'b1;
    wait_ps(2000, n);
    check("post_rst_period", n, 1024);
    check("post_rst_pwm_sum", hi_sum(), 0);
    check("post_rst_wr_ready", int'(wr_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
